// File: rtl/subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package subtractor_pkg;

   // Operand width used when the instantiating code does not override it
   localparam int DEFAULT_WIDTH = 8;

   // Control FSM encoding
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_t;

endpackage

// File: rtl/subtractor_serial_full_subtractor.sv
// One-bit full subtractor: diff = a - b - bin, with borrow out.
// Latency: combinational.
// Backpressure: none.
module full_subtractor (
   output logic diff,
   output logic bout,
   input  logic a,
   input  logic b,
   input  logic bin
);

   // Borrow is generated when b > a, or propagated when a == b and a borrow came in
   always_comb begin
      diff = a ^ b ^ bin;
      bout = (~a & b) | (~(a ^ b) & bin);
   end

endmodule

// File: rtl/subtractor_serial.sv
// Bit-serial unsigned subtractor, one bit per cycle LSB first; out = {borrow, in0 - in1}.
// Latency: WIDTH CALC cycles then one DONE cycle; one result per WIDTH+1 cycles back-to-back.
// Backpressure: none; start is ignored while busy and accepted only in IDLE or DONE.
module subtractor_serial
   import subtractor_pkg::*;
#(
   parameter int WIDTH = DEFAULT_WIDTH   // must be >= 2
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             start,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   output logic [WIDTH:0]   out,
   output logic             busy,
   output logic             done
);

   // Counter must be able to hold the value WIDTH itself
   localparam int CW = $clog2(WIDTH) + 1;

   state_t             state;
   logic [WIDTH-1:0]   a_q;        // minuend, shifted right so bit 0 is the live bit
   logic [WIDTH-1:0]   b_q;        // subtrahend, same alignment as a_q
   logic [WIDTH-2:0]   diff_q;     // difference bits so far, newest at the MSB
   logic               borrow_q;   // borrow into the current bit position
   logic [CW-1:0]      cnt;        // number of bits already processed

   logic               diff_bit;
   logic               bout;
   logic [WIDTH-1:0]   diff_shift;

   full_subtractor u_fs (
      .diff (diff_bit),
      .bout (bout),
      .a    (a_q[0]),
      .b    (b_q[0]),
      .bin  (borrow_q)
   );

   // Difference register with this cycle's bit inserted at the top; on the last
   // bit this is exactly the finished WIDTH-bit difference.
   always_comb begin
      diff_shift = {diff_bit, diff_q};
   end

   // Control FSM plus datapath registers; busy/done are registered alongside the state
   always_ff @(posedge clk) begin
      if (!resetn) begin
         state    <= IDLE;
         a_q      <= '0;
         b_q      <= '0;
         diff_q   <= '0;
         borrow_q <= 1'b0;
         cnt      <= '0;
         out      <= '0;
         busy     <= 1'b0;
         done     <= 1'b0;
      end else begin
         done <= 1'b0;
         case (state)
            IDLE, DONE: begin
               if (start) begin
                  a_q      <= in0;
                  b_q      <= in1;
                  diff_q   <= '0;
                  borrow_q <= 1'b0;
                  cnt      <= '0;
                  busy     <= 1'b1;
                  state    <= CALC;
               end else begin
                  state <= IDLE;
               end
            end
            CALC: begin
               a_q      <= a_q >> 1;
               b_q      <= b_q >> 1;
               diff_q   <= diff_shift[WIDTH-1:1];
               borrow_q <= bout;
               cnt      <= cnt + CW'(1);
               if (cnt == CW'(WIDTH - 1)) begin
                  out   <= {bout, diff_shift};
                  busy  <= 1'b0;
                  done  <= 1'b1;
                  state <= DONE;
               end
            end
            default: begin
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_subtractor_serial.sv
// Directed bench for subtractor_serial (WIDTH = 8) with hand-computed results.
// Latency: expects done 9 cycles after the cycle start is raised, busy for 8.
// Backpressure: exercises back-to-back start, ignored mid-CALC start and reset abort.
module tb_subtractor_serial;

   logic       clk = 1'b0;
   logic       resetn;
   logic       start;
   logic [7:0] in0;
   logic [7:0] in1;
   logic [8:0] out;
   logic       busy;
   logic       done;

   int checks = 0;
   int errors = 0;

   subtractor_serial #(.WIDTH(8)) dut (
      .clk    (clk),
      .resetn (resetn),
      .start  (start),
      .in0    (in0),
      .in1    (in1),
      .out    (out),
      .busy   (busy),
      .done   (done)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Run one operation. lat counts negedges from the cycle start was raised until done
   // is seen. disturb_at: CALC cycle at which to pulse start with new operands.
   // reset_at: CALC cycle at which to pulse reset (with start held high) and abort.
   task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                         input int disturb_at, input int reset_at,
                         output logic [8:0] res, output int lat, output int busy_n);
      @(negedge clk);
      in0 = a; in1 = b; start = 1'b1;
      @(negedge clk);
      start = 1'b0;
      lat = 1;
      busy_n = 0;
      while (!done && lat < 40) begin
         if (busy) busy_n++;
         if (lat == reset_at) begin
            resetn = 1'b0; start = 1'b1;
            @(negedge clk);
            resetn = 1'b1; start = 1'b0;
            break;
         end
         if (lat == disturb_at) begin
            in0 = 8'hAA; in1 = 8'h01; start = 1'b1;
         end else if (lat == disturb_at + 1) begin
            start = 1'b0;
         end
         @(negedge clk);
         lat++;
      end
      res = out;
   endtask

   // Watch n cycles, counting done pulses and busy cycles
   task automatic quiet(input int n, output int pulses, output int busy_seen);
      pulses = 0;
      busy_seen = 0;
      for (int i = 0; i < n; i++) begin
         @(negedge clk);
         if (done) pulses++;
         if (busy) busy_seen++;
      end
   endtask

   logic [7:0] va [4];
   logic [7:0] vb [4];
   logic [8:0] vexp [4];
   logic [8:0] res;
   int lat, busy_n, pulses, busy_seen, cyc, first, second;

   initial begin
      va   = '{8'd100,  8'd5,    8'hFF,  8'd0};
      vb   = '{8'd58,   8'd10,   8'hFF,  8'd0};
      vexp = '{9'h02A,  9'h1FB,  9'h000, 9'h000};

      resetn = 1'b0; start = 1'b0; in0 = '0; in1 = '0;
      repeat (3) @(negedge clk);
      check("reset_out",  out,  0);
      check("reset_busy", busy, 0);
      check("reset_done", done, 0);
      resetn = 1'b1;

      // Basic vectors: result, latency, busy length, done is a single-cycle pulse
      for (int i = 0; i < 4; i++) begin
         run_op(va[i], vb[i], -5, -5, res, lat, busy_n);
         check($sformatf("vec%0d_out", i), res, vexp[i]);
         check($sformatf("vec%0d_lat", i), lat, 9);
         check($sformatf("vec%0d_busy", i), busy_n, 8);
         @(negedge clk);
         check($sformatf("vec%0d_done_width", i), done, 0);
         check($sformatf("vec%0d_out_hold", i), out, vexp[i]);
      end

      // Back-to-back: start held high, 200-1 then 0-1
      @(negedge clk);
      in0 = 8'd200; in1 = 8'd1; start = 1'b1;
      @(negedge clk);
      in0 = 8'd0; in1 = 8'd1;
      cyc = 1; first = 0; second = 0;
      while (cyc < 60) begin
         if (done) begin
            if (first == 0) begin
               first = cyc;
               check("b2b_first_out", out, 9'h0C7);
            end else begin
               second = cyc;
               check("b2b_second_out", out, 9'h1FF);
               start = 1'b0;
               break;
            end
         end
         @(negedge clk);
         cyc++;
      end
      check("b2b_first_lat", first, 9);
      check("b2b_spacing", second - first, 9);
      quiet(12, pulses, busy_seen);
      check("b2b_no_extra_done", pulses, 0);
      check("b2b_no_extra_busy", busy_seen, 0);

      // Reset at CALC cycle 4 with start also high: abort, no done, out cleared
      run_op(8'd50, 8'd20, -5, 4, res, lat, busy_n);
      check("rst_out", out, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      quiet(12, pulses, busy_seen);
      check("rst_no_done", pulses, 0);
      check("rst_no_busy", busy_seen, 0);
      run_op(8'd7, 8'd3, -5, -5, res, lat, busy_n);
      check("after_rst_out", res, 9'h004);
      check("after_rst_lat", lat, 9);

      // Start and operand change mid-CALC are ignored and not queued
      run_op(8'd9, 8'd4, 3, -5, res, lat, busy_n);
      check("disturb_out", res, 9'h005);
      check("disturb_lat", lat, 9);
      quiet(12, pulses, busy_seen);
      check("disturb_no_queue_done", pulses, 0);
      check("disturb_no_queue_busy", busy_seen, 0);
      check("disturb_out_hold", out, 9'h005);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
